// File: rtl/decoder_nto2n_seq_if.sv
// Request/beat bundle between the control sequencer and the one-hot decoder.
// No logic of its own; latency and flow control are defined by the decoder.
// Both sides handshake valid/ready; the decoder side never looks at out_ready to set in_ready.
interface decoder_nto2n_seq_if #(
    parameter int SEL_W = 2
) ();
    localparam int OUT_W = 1 << SEL_W;

    // request side
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_sel;
    logic             in_mode;

    // beat side
    logic [OUT_W-1:0] out_onehot;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    // status
    logic             busy;

    // sequencer / bench side
    modport master (
        output in_valid,
        output in_sel,
        output in_mode,
        output out_ready,
        input  in_ready,
        input  out_onehot,
        input  out_valid,
        input  out_last,
        input  busy
    );

    // decoder side
    modport slave (
        input  in_valid,
        input  in_sel,
        input  in_mode,
        input  out_ready,
        output in_ready,
        output out_onehot,
        output out_valid,
        output out_last,
        output busy
    );
endinterface

// File: rtl/decoder_nto2n_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder: DIRECT emits one beat, SCAN walks all outputs from start.
// Latency: one cycle from request accept to first visible beat; one beat per accepted output transfer.
// Backpressure: beats hold stable while out_ready is low; no request accepted until back in IDLE.
module decoder_nto2n_seq #(
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    decoder_nto2n_seq_if.slave dec
);
    localparam int OUT_W = 1 << SEL_W;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state;
    logic             mode_q;     // 0 = DIRECT, 1 = SCAN
    logic [SEL_W-1:0] start_q;    // first position of the current request
    logic [SEL_W-1:0] pos_q;      // position currently presented
    logic [SEL_W-1:0] cnt_q;      // beats already consumed in this request
    logic [OUT_W-1:0] onehot_q;
    logic             valid_q;
    logic             last_q;

    logic             in_ready_w;
    logic             accept;
    logic             consume;
    logic [SEL_W-1:0] pos_nxt;
    logic [SEL_W-1:0] cnt_nxt;

    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] sel);
        decode      = '0;
        decode[sel] = 1'b1;
    endfunction

    // Request acceptance depends on state only, so the upstream never waits on the beat consumer.
    assign in_ready_w = (state == IDLE) && !rst;
    assign accept     = dec.in_valid && in_ready_w;
    assign consume    = valid_q && dec.out_ready;

    // Position and count wrap naturally at SEL_W bits.
    assign pos_nxt    = pos_q + SEL_W'(1);
    assign cnt_nxt    = cnt_q + SEL_W'(1);

    // Single FSM: latches the request, presents beats, advances the scan on each consumed beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mode_q   <= 1'b0;
            start_q  <= '0;
            pos_q    <= '0;
            cnt_q    <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= EMIT;
                        mode_q   <= dec.in_mode;
                        start_q  <= dec.in_sel;
                        pos_q    <= dec.in_sel;
                        cnt_q    <= '0;
                        onehot_q <= decode(dec.in_sel);
                        valid_q  <= 1'b1;
                        // DIRECT is a single beat; SCAN always has at least two beats
                        last_q   <= !dec.in_mode;
                    end
                end
                EMIT: begin
                    if (consume) begin
                        if (!mode_q || last_q) begin
                            state    <= IDLE;
                            onehot_q <= '0;
                            valid_q  <= 1'b0;
                            last_q   <= 1'b0;
                        end else begin
                            pos_q    <= pos_nxt;
                            cnt_q    <= cnt_nxt;
                            onehot_q <= decode(pos_nxt);
                            last_q   <= (cnt_nxt == SEL_W'(OUT_W - 1));
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    onehot_q <= '0;
                    valid_q  <= 1'b0;
                    last_q   <= 1'b0;
                end
            endcase
        end
    end

    assign dec.in_ready   = in_ready_w;
    assign dec.out_onehot = onehot_q;
    assign dec.out_valid  = valid_q;
    assign dec.out_last   = last_q;
    assign dec.busy       = (state != IDLE);

    // A presented beat is exactly one-hot; an empty cycle drives all zeros.
    a_onehot: assert property (@(posedge clk) disable iff (rst)
        valid_q |-> $onehot(onehot_q));
    a_zero_idle: assert property (@(posedge clk)
        !valid_q |-> (onehot_q == '0));

    // Busy and valid are the same condition seen from two angles.
    a_busy_valid: assert property (@(posedge clk)
        (state != IDLE) == valid_q);

    // A stalled beat must not change or vanish.
    a_hold: assert property (@(posedge clk) disable iff (rst)
        (valid_q && !dec.out_ready) |=> (valid_q && $stable(onehot_q) && $stable(last_q)));

    // The final SCAN beat lands one position before the start.
    a_scan_last: assert property (@(posedge clk) disable iff (rst)
        (valid_q && mode_q && last_q) |-> (onehot_q == decode(start_q - SEL_W'(1))));
endmodule

// File: tb/tb_decoder_nto2n_seq.sv
module tb_decoder_nto2n_seq;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    decoder_nto2n_seq_if #(.SEL_W(2)) ifa ();
    decoder_nto2n_seq_if #(.SEL_W(3)) ifb ();

    decoder_nto2n_seq #(.SEL_W(2)) dut_a (.clk(clk), .rst(rst), .dec(ifa));
    decoder_nto2n_seq #(.SEL_W(3)) dut_b (.clk(clk), .rst(rst), .dec(ifb));

    typedef struct packed {
        logic [7:0] oh;
        logic       last;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];
    int    tests = 0;
    int    fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] oh, input logic last);
        qa.push_back('{oh: oh, last: last});
    endtask

    task automatic push_b(input logic [7:0] oh, input logic last);
        qb.push_back('{oh: oh, last: last});
    endtask

    task automatic issue_a(input logic [1:0] sel, input logic mode);
        int n = 0;
        while (!ifa.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("ready_before_issue_a", 32'(ifa.in_ready), 32'd1);
        ifa.in_valid = 1'b1;
        ifa.in_sel   = sel;
        ifa.in_mode  = mode;
        tick();
        ifa.in_valid = 1'b0;
    endtask

    task automatic issue_b(input logic [2:0] sel, input logic mode);
        int n = 0;
        while (!ifb.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("ready_before_issue_b", 32'(ifb.in_ready), 32'd1);
        ifb.in_valid = 1'b1;
        ifb.in_sel   = sel;
        ifb.in_mode  = mode;
        tick();
        ifb.in_valid = 1'b0;
    endtask

    task automatic drain_a(input bit toggle_ready);
        int n = 0;
        while ((qa.size() != 0 || !ifa.in_ready) && n < 100) begin
            if (toggle_ready) ifa.out_ready = ~ifa.out_ready;
            tick();
            n++;
        end
        check("drain_a", 32'(qa.size() == 0 && ifa.in_ready), 32'd1);
    endtask

    task automatic drain_b;
        int n = 0;
        while ((qb.size() != 0 || !ifb.in_ready) && n < 100) begin
            tick();
            n++;
        end
        check("drain_b", 32'(qb.size() == 0 && ifb.in_ready), 32'd1);
    endtask

    // Monitor for DUT A: every consumed beat must match the head of the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            check("busy_eq_valid_a", 32'(ifa.busy), 32'(ifa.out_valid));
            if (!ifa.out_valid) check("zero_when_idle_a", 32'(ifa.out_onehot), 32'd0);
            if (ifa.out_valid && ifa.out_ready) begin
                if (qa.size() == 0) begin
                    check("unexpected_beat_a", 32'(ifa.out_onehot), 32'hdead);
                end else begin
                    e = qa.pop_front();
                    check("beat_a", {23'd0, 4'd0, ifa.out_onehot, ifa.out_last}, {23'd0, e});
                end
            end
        end
    end

    // Monitor for DUT B.
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            check("busy_eq_valid_b", 32'(ifb.busy), 32'(ifb.out_valid));
            if (!ifb.out_valid) check("zero_when_idle_b", 32'(ifb.out_onehot), 32'd0);
            if (ifb.out_valid && ifb.out_ready) begin
                if (qb.size() == 0) begin
                    check("unexpected_beat_b", 32'(ifb.out_onehot), 32'hdead);
                end else begin
                    e = qb.pop_front();
                    check("beat_b", {23'd0, ifb.out_onehot, ifb.out_last}, {23'd0, e});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.in_valid = 1'b0; ifa.in_sel = '0; ifa.in_mode = 1'b0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_sel = '0; ifb.in_mode = 1'b0; ifb.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();

        // reset state
        check("rst_valid_a",  32'(ifa.out_valid),  32'd0);
        check("rst_onehot_a", 32'(ifa.out_onehot), 32'd0);
        check("rst_last_a",   32'(ifa.out_last),   32'd0);
        check("rst_busy_a",   32'(ifa.busy),       32'd0);
        check("rst_ready_a",  32'(ifa.in_ready),   32'd0);
        check("rst_valid_b",  32'(ifb.out_valid),  32'd0);
        check("rst_ready_b",  32'(ifb.in_ready),   32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst_a", 32'(ifa.in_ready), 32'd1);

        // 1: DIRECT sel=2, consumer always ready
        ifa.out_ready = 1'b1;
        push_a(8'h04, 1'b1);
        issue_a(2'd2, 1'b0);
        check("t1_valid",    32'(ifa.out_valid),  32'd1);
        check("t1_onehot",   32'(ifa.out_onehot), 32'h4);
        check("t1_last",     32'(ifa.out_last),   32'd1);
        check("t1_in_ready", 32'(ifa.in_ready),   32'd0);
        tick();
        check("t1_valid_after", 32'(ifa.out_valid), 32'd0);
        check("t1_ready_after", 32'(ifa.in_ready),  32'd1);

        // 2: DIRECT sel=3 stalled for 5 cycles; input changes during stall ignored
        ifa.out_ready = 1'b0;
        push_a(8'h08, 1'b1);
        issue_a(2'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            ifa.in_sel  = 2'(i);
            ifa.in_mode = 1'b1;
            check("t2_hold_onehot", 32'(ifa.out_onehot), 32'h8);
            check("t2_hold_valid",  32'(ifa.out_valid),  32'd1);
            check("t2_hold_ready",  32'(ifa.in_ready),   32'd0);
            tick();
        end
        ifa.out_ready = 1'b1;
        tick();
        check("t2_idle_valid", 32'(ifa.out_valid), 32'd0);
        check("t2_idle_ready", 32'(ifa.in_ready),  32'd1);

        // 3: SCAN from 2
        push_a(8'h04, 1'b0);
        push_a(8'h08, 1'b0);
        push_a(8'h01, 1'b0);
        push_a(8'h02, 1'b1);
        issue_a(2'd2, 1'b1);
        drain_a(1'b0);

        // 4: SCAN from 0 with out_ready toggling
        push_a(8'h01, 1'b0);
        push_a(8'h02, 1'b0);
        push_a(8'h04, 1'b0);
        push_a(8'h08, 1'b1);
        issue_a(2'd0, 1'b1);
        drain_a(1'b1);
        ifa.out_ready = 1'b1;

        // 5: reset while the second SCAN beat is presented
        push_a(8'h01, 1'b0);
        push_a(8'h02, 1'b0);
        issue_a(2'd0, 1'b1);
        tick();
        check("t5_beat2", 32'(ifa.out_onehot), 32'h2);
        rst = 1'b1;
        tick();
        check("t5_valid", 32'(ifa.out_valid),  32'd0);
        check("t5_onehot", 32'(ifa.out_onehot), 32'd0);
        check("t5_busy",  32'(ifa.busy),       32'd0);
        check("t5_last",  32'(ifa.out_last),   32'd0);
        check("t5_ready_in_rst", 32'(ifa.in_ready), 32'd0);
        qa.delete();
        rst = 1'b0;
        #1;
        check("t5_ready_after", 32'(ifa.in_ready), 32'd1);
        // no leftover beats from the aborted scan
        push_a(8'h02, 1'b1);
        issue_a(2'd1, 1'b0);
        drain_a(1'b0);

        // 6: SEL_W=3 SCAN from 7; a competing request during the scan is ignored
        ifb.out_ready = 1'b1;
        push_b(8'h80, 1'b0);
        push_b(8'h01, 1'b0);
        push_b(8'h02, 1'b0);
        push_b(8'h04, 1'b0);
        push_b(8'h08, 1'b0);
        push_b(8'h10, 1'b0);
        push_b(8'h20, 1'b0);
        push_b(8'h40, 1'b1);
        issue_b(3'd7, 1'b1);
        ifb.in_valid = 1'b1;
        ifb.in_mode  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ifb.in_sel = 3'(i + 3);
            check("t6_busy", 32'(ifb.busy), 32'd1);
            tick();
        end
        ifb.in_valid = 1'b0;
        drain_b();

        // SEL_W=3 DIRECT with a short stall
        ifb.out_ready = 1'b0;
        push_b(8'h20, 1'b1);
        issue_b(3'd5, 1'b0);
        tick();
        check("t6_direct_hold", 32'(ifb.out_onehot), 32'h20);
        ifb.out_ready = 1'b1;
        drain_b();

        repeat (3) tick();
        check("end_queue_a", 32'(qa.size()), 32'd0);
        check("end_queue_b", 32'(qb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
